// File: rtl/jtdsp16_pc_seq.sv
`default_nettype none
// ============================================================================
//  Module      : jtdsp16_pc_seq
//  Description : DSP16 program-counter sequencer. Holds pc and the XAAU
//                pointer registers (pr, pi, pt, i_reg). Each enabled cycle
//                pc increments, jumps, or enters an interrupt handler.
//                Optional feature macro: JTDSP16_IRQ_EN (interrupt entry,
//                icall and in_irq tracking). Without it, ext_irq and icall
//                are ignored and ireturn acts as a plain goto pi.
//  Revision    : 1.0 - initial release
// ============================================================================
module jtdsp16_pc_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic        goto_ja,
  input  logic        call_ja,
  input  logic        goto_b,
  input  logic        icall,
  input  logic        pc_halt,
  input  logic        xaau_imm_load,
  input  logic        xaau_ram_load,
  input  logic [2:0]  r_field,
  input  logic [11:0] i_field,
  input  logic [15:0] long_imm,
  input  logic [15:0] ram_dout,
  input  logic        ext_irq,
  output logic [15:0] rom_addr,
  output logic [15:0] pr,
  output logic [15:0] pi,
  output logic [15:0] pt,
  output logic [11:0] i_reg,
  output logic        in_irq
);

  // goto_b subcodes (i_field[10:8])
  localparam logic [2:0] C_B_RETURN  = 3'd0;
  localparam logic [2:0] C_B_IRETURN = 3'd1;
  localparam logic [2:0] C_B_GOTO_PT = 3'd2;
  localparam logic [2:0] C_B_CALL_PT = 3'd3;

  // XAAU destination codes (r_field)
  localparam logic [2:0] C_R_PT   = 3'd0;
  localparam logic [2:0] C_R_PR   = 3'd1;
  localparam logic [2:0] C_R_PI   = 3'd2;
  localparam logic [2:0] C_R_IREG = 3'd3;

  // Fixed handler entry points
  localparam logic [15:0] C_VEC_EXT   = 16'h0001;
  localparam logic [15:0] C_VEC_ICALL = 16'h0002;

  logic [15:0] pc_q,   pc_d;
  logic [15:0] pr_q,   pr_d;
  logic [15:0] pi_q,   pi_d;
  logic [15:0] pt_q,   pt_d;
  logic [11:0] ireg_q, ireg_d;

  logic [15:0] w_pc_inc;
  logic [15:0] w_pc_ja;
  logic [15:0] w_load_data;
  logic        w_load;
  logic [2:0]  w_b_sub;

  assign w_pc_inc    = pc_q + 16'd1;            // wraps 0xFFFF -> 0x0000
  assign w_pc_ja     = {pc_q[15:12], i_field};  // page-relative jump target
  assign w_load      = xaau_imm_load | xaau_ram_load;
  assign w_load_data = xaau_ram_load ? ram_dout : long_imm;  // RAM wins
  assign w_b_sub     = i_field[10:8];

`ifdef JTDSP16_IRQ_EN
  logic in_irq_q, in_irq_d;
`else
  // Interrupt inputs have no effect in this build.
  logic w_unused_irq;
  assign w_unused_irq = icall ^ ext_irq;
`endif

  // Next-state: register loads first, then program flow overrides them so
  // a jump writing pr/pi beats a load to the same register.
  always_comb begin
    pc_d   = pc_q;
    pr_d   = pr_q;
    pi_d   = pi_q;
    pt_d   = pt_q;
    ireg_d = ireg_q;
`ifdef JTDSP16_IRQ_EN
    in_irq_d = in_irq_q;
`endif

    if (w_load) begin
      case (r_field)
        C_R_PT:   pt_d   = w_load_data;
        C_R_PR:   pr_d   = w_load_data;
        C_R_PI:   pi_d   = w_load_data;
        C_R_IREG: ireg_d = w_load_data[11:0];
        default:  ;
      endcase
    end

    // A halted cycle freezes pc and defers any jump or interrupt entry.
    if (!pc_halt) begin
      if (call_ja) begin
        pr_d = pc_q;
        pc_d = w_pc_ja;
      end else if (goto_ja) begin
        pc_d = w_pc_ja;
      end else if (goto_b) begin
        case (w_b_sub)
          C_B_RETURN:  pc_d = pr_q;
          C_B_IRETURN: begin
            pc_d = pi_q;
`ifdef JTDSP16_IRQ_EN
            in_irq_d = 1'b0;
`endif
          end
          C_B_GOTO_PT: pc_d = pt_q;
          C_B_CALL_PT: begin
            pr_d = pc_q;
            pc_d = pt_q;
          end
          default:     pc_d = w_pc_inc;
        endcase
      end
`ifdef JTDSP16_IRQ_EN
      else if (icall) begin
        pi_d     = pc_q;
        pc_d     = C_VEC_ICALL;
        in_irq_d = 1'b1;
      end else if (ext_irq && !in_irq_q) begin
        // Level request; masked while a handler is active. After ireturn
        // in_irq_q is low from the next cycle, so re-entry is one cycle late.
        pi_d     = pc_q;
        pc_d     = C_VEC_EXT;
        in_irq_d = 1'b1;
      end
`endif
      else begin
        pc_d = w_pc_inc;
      end
    end
  end

  // Sequencer state register, gated by the clock enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q   <= 16'h0000;
      pr_q   <= 16'h0000;
      pi_q   <= 16'h0000;
      pt_q   <= 16'h0000;
      ireg_q <= 12'h000;
    end else if (cen) begin
      pc_q   <= pc_d;
      pr_q   <= pr_d;
      pi_q   <= pi_d;
      pt_q   <= pt_d;
      ireg_q <= ireg_d;
    end
  end

`ifdef JTDSP16_IRQ_EN
  // Interrupt-active flag, gated by the clock enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_irq_q <= 1'b0;
    end else if (cen) begin
      in_irq_q <= in_irq_d;
    end
  end

  assign in_irq = in_irq_q;
`else
  assign in_irq = 1'b0;
`endif

  assign rom_addr = pc_q;
  assign pr       = pr_q;
  assign pi       = pi_q;
  assign pt       = pt_q;
  assign i_reg    = ireg_q;

endmodule
`default_nettype wire

// File: tb/tb_jtdsp16_pc_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jtdsp16_pc_seq
//  Description : Directed self-checking bench for jtdsp16_pc_seq. Interrupt
//                scenarios follow the JTDSP16_IRQ_EN build setting.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_jtdsp16_pc_seq;

  logic        clk = 1'b0;
  logic        rst, cen, goto_ja, call_ja, goto_b, icall, pc_halt;
  logic        xaau_imm_load, xaau_ram_load, ext_irq;
  logic [2:0]  r_field;
  logic [11:0] i_field;
  logic [15:0] long_imm, ram_dout;
  logic [15:0] rom_addr, pr, pi, pt;
  logic [11:0] i_reg;
  logic        in_irq;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  jtdsp16_pc_seq dut (
    .clk(clk), .rst(rst), .cen(cen),
    .goto_ja(goto_ja), .call_ja(call_ja), .goto_b(goto_b), .icall(icall),
    .pc_halt(pc_halt), .xaau_imm_load(xaau_imm_load),
    .xaau_ram_load(xaau_ram_load), .r_field(r_field), .i_field(i_field),
    .long_imm(long_imm), .ram_dout(ram_dout), .ext_irq(ext_irq),
    .rom_addr(rom_addr), .pr(pr), .pi(pi), .pt(pt), .i_reg(i_reg),
    .in_irq(in_irq)
  );

  task automatic idle();
    goto_ja = 0; call_ja = 0; goto_b = 0; icall = 0; pc_halt = 0;
    xaau_imm_load = 0; xaau_ram_load = 0; ext_irq = 0;
    r_field = 3'd0; i_field = 12'h000; long_imm = 16'h0; ram_dout = 16'h0;
  endtask

  // One clock; outputs are stable 1 ns after the edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    cen = 1;
    rst = 1;
    cycle();
    rst = 0;
  endtask

  // Drive pc to an arbitrary value through pt + goto pt.
  task automatic set_pc(input logic [15:0] v);
    idle();
    xaau_imm_load = 1; r_field = 3'd0; long_imm = v;
    cycle();
    idle();
    goto_b = 1; i_field = 12'h200;
    cycle();
    idle();
  endtask

  task automatic test_reset();
    idle();
    cen = 1;
    rst = 1;
    #3;
    checks++; if (rom_addr !== 16'h0000) begin errors++; $display("FAIL reset_pc got=%h exp=0000", rom_addr); end
    checks++; if (pr !== 16'h0000) begin errors++; $display("FAIL reset_pr got=%h exp=0000", pr); end
    checks++; if (pi !== 16'h0000) begin errors++; $display("FAIL reset_pi got=%h exp=0000", pi); end
    checks++; if (pt !== 16'h0000) begin errors++; $display("FAIL reset_pt got=%h exp=0000", pt); end
    checks++; if (i_reg !== 12'h000) begin errors++; $display("FAIL reset_ireg got=%h exp=000", i_reg); end
    checks++; if (in_irq !== 1'b0) begin errors++; $display("FAIL reset_in_irq got=%b exp=0", in_irq); end
    cycle();
    rst = 0;
    for (int k = 1; k <= 5; k++) begin
      cycle();
      checks++; if (rom_addr !== 16'(k)) begin errors++; $display("FAIL step_%0d got=%h exp=%h", k, rom_addr, 16'(k)); end
    end
  endtask

  task automatic test_call_return();
    set_pc(16'h1234);
    checks++; if (rom_addr !== 16'h1234) begin errors++; $display("FAIL goto_pt got=%h exp=1234", rom_addr); end
    call_ja = 1; i_field = 12'h056;
    cycle(); idle();
    checks++; if (rom_addr !== 16'h1056) begin errors++; $display("FAIL call_ja_pc got=%h exp=1056", rom_addr); end
    checks++; if (pr !== 16'h1234) begin errors++; $display("FAIL call_ja_pr got=%h exp=1234", pr); end
    goto_b = 1; i_field = 12'h000;
    cycle(); idle();
    checks++; if (rom_addr !== 16'h1234) begin errors++; $display("FAIL return_pc got=%h exp=1234", rom_addr); end
    goto_ja = 1; i_field = 12'hABC;
    cycle(); idle();
    checks++; if (rom_addr !== 16'h1ABC) begin errors++; $display("FAIL goto_ja got=%h exp=1abc", rom_addr); end
    // unused subcode just increments
    goto_b = 1; i_field = 12'h500;
    cycle(); idle();
    checks++; if (rom_addr !== 16'h1ABD) begin errors++; $display("FAIL goto_b_sub5 got=%h exp=1abd", rom_addr); end
  endtask

  task automatic test_xaau();
    // pr=0x0020, then return to it while loading pt in the same cycle
    xaau_imm_load = 1; r_field = 3'd1; long_imm = 16'h0020;
    cycle(); idle();
    goto_b = 1; i_field = 12'h000;
    xaau_imm_load = 1; r_field = 3'd0; long_imm = 16'hBEEF;
    cycle(); idle();
    checks++; if (pt !== 16'hBEEF) begin errors++; $display("FAIL load_pt got=%h exp=beef", pt); end
    checks++; if (rom_addr !== 16'h0020) begin errors++; $display("FAIL ret_to_20 got=%h exp=0020", rom_addr); end
    goto_b = 1; i_field = 12'h300;
    cycle(); idle();
    checks++; if (rom_addr !== 16'hBEEF) begin errors++; $display("FAIL call_pt_pc got=%h exp=beef", rom_addr); end
    checks++; if (pr !== 16'h0020) begin errors++; $display("FAIL call_pt_pr got=%h exp=0020", pr); end
    // both strobes: RAM data wins; i_reg keeps low 12 bits
    xaau_imm_load = 1; xaau_ram_load = 1; r_field = 3'd3;
    long_imm = 16'h1111; ram_dout = 16'hABCD;
    cycle(); idle();
    checks++; if (i_reg !== 12'hBCD) begin errors++; $display("FAIL ram_wins_ireg got=%h exp=bcd", i_reg); end
    xaau_ram_load = 1; r_field = 3'd2; ram_dout = 16'h5A5A;
    cycle(); idle();
    checks++; if (pi !== 16'h5A5A) begin errors++; $display("FAIL load_pi got=%h exp=5a5a", pi); end
    // code 5 writes nothing
    xaau_imm_load = 1; r_field = 3'd5; long_imm = 16'h7777;
    cycle(); idle();
    checks++; if ({pt, pr, pi, i_reg} !== {16'hBEEF, 16'h0020, 16'h5A5A, 12'hBCD})
      begin errors++; $display("FAIL load_code5 got=%h/%h/%h/%h exp=beef/0020/5a5a/bcd", pt, pr, pi, i_reg); end
    // call_ja and pr load in the same cycle: call's write wins
    set_pc(16'h3100);
    call_ja = 1; i_field = 12'h222;
    xaau_imm_load = 1; r_field = 3'd1; long_imm = 16'h9999;
    cycle(); idle();
    checks++; if (pr !== 16'h3100) begin errors++; $display("FAIL jump_beats_load got=%h exp=3100", pr); end
    // call_ja > goto_ja > goto_b
    call_ja = 1; goto_ja = 1; goto_b = 1; i_field = 12'h044;
    cycle(); idle();
    checks++; if (rom_addr !== 16'h3044 || pr !== 16'h3222) begin errors++; $display("FAIL prec_call got=%h/%h exp=3044/3222", rom_addr, pr); end
    goto_ja = 1; goto_b = 1; i_field = 12'h0FF;  // subcode 0 would return to pr
    cycle(); idle();
    checks++; if (rom_addr !== 16'h30FF) begin errors++; $display("FAIL prec_goto got=%h exp=30ff", rom_addr); end
  endtask

  task automatic test_halt_wrap();
    set_pc(16'h0040);
    pc_halt = 1; goto_ja = 1; i_field = 12'h777;
    xaau_imm_load = 1; r_field = 3'd0; long_imm = 16'h4242;
    cycle(); idle();
    checks++; if (rom_addr !== 16'h0040) begin errors++; $display("FAIL halt_pc got=%h exp=0040", rom_addr); end
    checks++; if (pt !== 16'h4242) begin errors++; $display("FAIL halt_load got=%h exp=4242", pt); end
    set_pc(16'hFFFF);
    cycle();
    checks++; if (rom_addr !== 16'h0000) begin errors++; $display("FAIL wrap got=%h exp=0000", rom_addr); end
    cen = 0;
    goto_ja = 1; i_field = 12'h123;
    xaau_imm_load = 1; r_field = 3'd0; long_imm = 16'h6666;
    repeat (3) cycle();
    idle();
    checks++; if (rom_addr !== 16'h0000) begin errors++; $display("FAIL cen_hold_pc got=%h exp=0000", rom_addr); end
    checks++; if (pt !== 16'hFFFF) begin errors++; $display("FAIL cen_hold_pt got=%h exp=ffff", pt); end
    cen = 1;
    cycle();
    checks++; if (rom_addr !== 16'h0001) begin errors++; $display("FAIL cen_resume got=%h exp=0001", rom_addr); end
  endtask

`ifdef JTDSP16_IRQ_EN
  task automatic test_irq();
    do_reset();
    goto_ja = 1; i_field = 12'h010;
    cycle(); idle();
    ext_irq = 1;
    cycle();
    checks++; if (rom_addr !== 16'h0001 || pi !== 16'h0010 || in_irq !== 1'b1)
      begin errors++; $display("FAIL irq_entry got=%h/%h/%b exp=0001/0010/1", rom_addr, pi, in_irq); end
    cycle(); cycle();
    checks++; if (rom_addr !== 16'h0003 || pi !== 16'h0010)
      begin errors++; $display("FAIL irq_no_reentry got=%h/%h exp=0003/0010", rom_addr, pi); end
    goto_b = 1; i_field = 12'h100;
    cycle();
    goto_b = 0;
    checks++; if (rom_addr !== 16'h0010 || in_irq !== 1'b0)
      begin errors++; $display("FAIL ireturn got=%h/%b exp=0010/0", rom_addr, in_irq); end
    cycle();
    checks++; if (rom_addr !== 16'h0001 || pi !== 16'h0010 || in_irq !== 1'b1)
      begin errors++; $display("FAIL irq_reentry got=%h/%h/%b exp=0001/0010/1", rom_addr, pi, in_irq); end
    idle();
    // software interrupt
    do_reset();
    goto_ja = 1; i_field = 12'h0A0;
    cycle(); idle();
    icall = 1;
    cycle(); idle();
    checks++; if (rom_addr !== 16'h0002 || pi !== 16'h00A0 || in_irq !== 1'b1)
      begin errors++; $display("FAIL icall got=%h/%h/%b exp=0002/00a0/1", rom_addr, pi, in_irq); end
    // halt defers interrupt entry
    do_reset();
    goto_ja = 1; i_field = 12'h040;
    cycle(); idle();
    pc_halt = 1; ext_irq = 1;
    cycle();
    checks++; if (rom_addr !== 16'h0040 || in_irq !== 1'b0)
      begin errors++; $display("FAIL halt_irq got=%h/%b exp=0040/0", rom_addr, in_irq); end
    pc_halt = 0;
    cycle(); idle();
    checks++; if (rom_addr !== 16'h0001 || pi !== 16'h0040 || in_irq !== 1'b1)
      begin errors++; $display("FAIL halt_irq_next got=%h/%h/%b exp=0001/0040/1", rom_addr, pi, in_irq); end
  endtask
`else
  task automatic test_irq();
    do_reset();
    goto_ja = 1; i_field = 12'h010;
    cycle(); idle();
    ext_irq = 1;
    cycle();
    checks++; if (rom_addr !== 16'h0011 || in_irq !== 1'b0 || pi !== 16'h0000)
      begin errors++; $display("FAIL irq_ignored got=%h/%b/%h exp=0011/0/0000", rom_addr, in_irq, pi); end
    ext_irq = 0; icall = 1;
    cycle(); idle();
    checks++; if (rom_addr !== 16'h0012 || pi !== 16'h0000)
      begin errors++; $display("FAIL icall_ignored got=%h/%h exp=0012/0000", rom_addr, pi); end
    xaau_imm_load = 1; r_field = 3'd2; long_imm = 16'h0C0C;
    cycle(); idle();
    goto_b = 1; i_field = 12'h100;
    cycle(); idle();
    checks++; if (rom_addr !== 16'h0C0C || in_irq !== 1'b0)
      begin errors++; $display("FAIL ireturn_goto_pi got=%h/%b exp=0c0c/0", rom_addr, in_irq); end
    goto_ja = 1; i_field = 12'h040;
    cycle(); idle();
    pc_halt = 1; ext_irq = 1;
    cycle();
    pc_halt = 0;
    cycle(); idle();
    checks++; if (rom_addr !== 16'h0041) begin errors++; $display("FAIL halt_then_inc got=%h exp=0041", rom_addr); end
  endtask
`endif

  task automatic test_reset_mid_op();
    set_pc(16'h2345);
    call_ja = 1; goto_b = 1; ext_irq = 1; i_field = 12'h111;
    #2 rst = 1;
    #1;
    checks++; if (rom_addr !== 16'h0000 || pr !== 16'h0000 || pt !== 16'h0000 || in_irq !== 1'b0)
      begin errors++; $display("FAIL async_reset got=%h/%h/%h/%b exp=0000/0000/0000/0", rom_addr, pr, pt, in_irq); end
    cycle();
    idle();
    rst = 0;
    checks++; if (rom_addr !== 16'h0000) begin errors++; $display("FAIL first_fetch got=%h exp=0000", rom_addr); end
    cycle();
    checks++; if (rom_addr !== 16'h0001) begin errors++; $display("FAIL after_reset_inc got=%h exp=0001", rom_addr); end
  endtask

  initial begin
    rst = 1; cen = 1;
    idle();
    test_reset();
    test_call_return();
    test_xaau();
    test_halt_wrap();
    test_irq();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net against a stalled run.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
